// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_pkg
//  Description : Shared types and constants for the PS/2 mouse packet
//                receiver: byte FSM states, byte0 bit positions, saturation
//                values and the axis assembly helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

    // Byte receiver states, one transition per filtered ps2_clk falling edge
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } ps2_rx_state_e;

    // Stream-mode packet length and byte0 field positions
    localparam int PKT_LEN = 3;
    localparam int B0_L    = 0;
    localparam int B0_R    = 1;
    localparam int B0_M    = 2;
    localparam int B0_SYNC = 3;
    localparam int B0_XS   = 4;
    localparam int B0_YS   = 5;
    localparam int B0_XO   = 6;
    localparam int B0_YO   = 7;

    // Overflowed axes clamp to the extreme 9-bit two's-complement values
    localparam logic [8:0] POS_SAT = 9'h0FF;
    localparam logic [8:0] NEG_SAT = 9'h100;

    // Build one signed 9-bit axis from its sign bit, overflow flag and low byte
    function automatic logic [8:0] axis_value(input logic sign_bit,
                                              input logic ovf_bit,
                                              input logic [7:0] low_byte);
        logic [8:0] v;
        if (ovf_bit)
            v = sign_bit ? NEG_SAT : POS_SAT;
        else
            v = {sign_bit, low_byte};
        return v;
    endfunction

endpackage : mouse_pkg
`default_nettype wire

// File: rtl/ps2_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_byte
//  Description : PS/2 device-to-host byte receiver. Synchronises and
//                deglitches the raw lines, shifts in start/data/parity/stop
//                on filtered clock falling edges and aborts stalled
//                transfers after an idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_byte
    import mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 128000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       pkt_busy,       // packet assembler is mid-packet
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       timeout_abort
);

    localparam int c_filt_w = $clog2(FILTER_LEN + 1);
    localparam int c_to_w   = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic                r_clk_filt;
    logic                r_clk_filt_d;
    logic                w_fall;
    logic                w_data;

    ps2_rx_state_e       r_state;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic                r_parity;
    logic [c_to_w-1:0]   r_to_cnt;
    logic [7:0]          r_byte_data;
    logic                r_byte_valid;
    logic                r_byte_err;
    logic                r_timeout_abort;

    // Two-flop synchronisers; both lines idle high
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    // Filtered clock follows the line only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_filt_w'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;
    assign w_data = r_data_sync[1];

    // Byte FSM and idle timeout; a falling edge always takes priority over the timeout
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= RX_IDLE;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_parity        <= 1'b0;
            r_to_cnt        <= '0;
            r_byte_data     <= '0;
            r_byte_valid    <= 1'b0;
            r_byte_err      <= 1'b0;
            r_timeout_abort <= 1'b0;
        end else begin
            r_byte_valid    <= 1'b0;
            r_byte_err      <= 1'b0;
            r_timeout_abort <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    RX_IDLE: begin
                        if (!w_data) begin
                            r_state   <= RX_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity across data+parity and a high stop bit
                        if ((^{r_parity, r_shift}) && w_data) begin
                            r_byte_data  <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_byte_err <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end else if (r_to_cnt == c_to_w'(TIMEOUT_CYCLES)) begin
                // Counter parks at the limit while idle; restart it after an abort so
                // the assembler's index clear is seen before the next evaluation
                if ((r_state != RX_IDLE) || pkt_busy) begin
                    r_state         <= RX_IDLE;
                    r_timeout_abort <= 1'b1;
                    r_to_cnt        <= '0;
                end
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign byte_data     = r_byte_data;
    assign byte_valid    = r_byte_valid;
    assign byte_err      = r_byte_err;
    assign timeout_abort = r_timeout_abort;

endmodule : ps2_rx_byte
`default_nettype wire

// File: rtl/ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_packet_rx
//  Description : Receive-only PS/2 mouse front end. Assembles 3-byte
//                stream-mode packets into saturated signed 9-bit deltas,
//                button levels and a per-packet toggle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet_rx
    import mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 128000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [8:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic       mouse_left,
    output logic       mouse_right,
    output logic       mouse_middle,
    output logic       input_pulse,
    output logic       packet_err
);

    logic [7:0] w_byte_data;
    logic       w_byte_valid;
    logic       w_byte_err;
    logic       w_timeout_abort;
    logic       w_pkt_busy;

    logic [1:0] r_pkt_idx;
    logic [7:0] r_b0;
    logic [7:0] r_b1;
    logic [8:0] r_mouse_x;
    logic [8:0] r_mouse_y;
    logic       r_left;
    logic       r_right;
    logic       r_middle;
    logic       r_pulse;
    logic       r_packet_err;

    assign w_pkt_busy = (r_pkt_idx != 2'd0);

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_byte (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_data_in   (ps2_data_in),
        .pkt_busy      (w_pkt_busy),
        .byte_data     (w_byte_data),
        .byte_valid    (w_byte_valid),
        .byte_err      (w_byte_err),
        .timeout_abort (w_timeout_abort)
    );

    // Packet index, holding registers and the output update on the third byte
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_idx    <= 2'd0;
            r_b0         <= '0;
            r_b1         <= '0;
            r_mouse_x    <= '0;
            r_mouse_y    <= '0;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_middle     <= 1'b0;
            r_pulse      <= 1'b0;
            r_packet_err <= 1'b0;
        end else begin
            r_packet_err <= 1'b0;
            if (w_timeout_abort || w_byte_err) begin
                r_pkt_idx    <= 2'd0;
                r_packet_err <= 1'b1;
            end else if (w_byte_valid) begin
                if (r_pkt_idx == 2'd0) begin
                    // Sync bit keeps the assembler aligned to header bytes
                    if (w_byte_data[B0_SYNC]) begin
                        r_b0      <= w_byte_data;
                        r_pkt_idx <= 2'd1;
                    end else begin
                        r_packet_err <= 1'b1;
                    end
                end else if (r_pkt_idx == 2'(PKT_LEN - 2)) begin
                    r_b1      <= w_byte_data;
                    r_pkt_idx <= 2'(PKT_LEN - 1);
                end else begin
                    r_mouse_x <= axis_value(r_b0[B0_XS], r_b0[B0_XO], r_b1);
                    r_mouse_y <= axis_value(r_b0[B0_YS], r_b0[B0_YO], w_byte_data);
                    r_left    <= r_b0[B0_L];
                    r_right   <= r_b0[B0_R];
                    r_middle  <= r_b0[B0_M];
                    r_pulse   <= ~r_pulse;
                    r_pkt_idx <= 2'd0;
                end
            end
        end
    end

    assign mouse_x      = r_mouse_x;
    assign mouse_y      = r_mouse_y;
    assign mouse_left   = r_left;
    assign mouse_right  = r_right;
    assign mouse_middle = r_middle;
    assign input_pulse  = r_pulse;
    assign packet_err   = r_packet_err;

endmodule : ps2_mouse_packet_rx
`default_nettype wire

// File: tb/tb_ps2_mouse_packet_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_mouse_packet_rx
//  Description : Directed self-checking bench for ps2_mouse_packet_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic [8:0] mouse_x;
    logic [8:0] mouse_y;
    logic       mouse_left;
    logic       mouse_right;
    logic       mouse_middle;
    logic       input_pulse;
    logic       packet_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_base;

    ps2_mouse_packet_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_left   (mouse_left),
        .mouse_right  (mouse_right),
        .mouse_middle (mouse_middle),
        .input_pulse  (input_pulse),
        .packet_err   (packet_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Count error pulses, sampled away from the active edge
    always @(negedge clk_sys) if (packet_err === 1'b1) err_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [8:0] x, input logic [8:0] y,
                           input logic [2:0] mrl, input logic pulse);
        chk({tag, ".x"}, 16'(mouse_x), 16'(x));
        chk({tag, ".y"}, 16'(mouse_y), 16'(y));
        chk({tag, ".btn"}, 16'({mouse_middle, mouse_right, mouse_left}), 16'(mrl));
        chk({tag, ".pulse"}, 16'(input_pulse), 16'(pulse));
    endtask

    // One device bit: data set while clock high, then a 20-cycle low phase
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data_in = b;
        repeat (10) @(posedge clk_sys);
        if (glitch) begin
            ps2_clk_in = 1'b0;
            repeat (3) @(posedge clk_sys);
            ps2_clk_in = 1'b1;
            repeat (5) @(posedge clk_sys);
        end
        ps2_clk_in = 1'b0;
        if (glitch) begin
            repeat (12) @(posedge clk_sys);
            ps2_clk_in = 1'b1;
            repeat (3) @(posedge clk_sys);
            ps2_clk_in = 1'b0;
            repeat (5) @(posedge clk_sys);
        end else begin
            repeat (20) @(posedge clk_sys);
        end
        ps2_clk_in = 1'b1;
        repeat (10) @(posedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit glitch);
        logic par;
        par = (~^d) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(1'b1, glitch);
        ps2_data_in = 1'b1;
        repeat (30) @(posedge clk_sys);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input bit glitch);
        send_byte(b0, 1'b0, glitch);
        send_byte(b1, 1'b0, glitch);
        send_byte(b2, 1'b0, glitch);
    endtask

    initial begin
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        chk_out("reset", 9'h000, 9'h000, 3'b000, 1'b0);
        chk("reset.err", 16'(packet_err), 16'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);

        // 1: left button, +5 / -5
        send_pkt(8'h29, 8'h05, 8'hFB, 1'b0);
        chk_out("t1", 9'h005, 9'h1FB, 3'b001, 1'b1);
        chk("t1.err", 16'(err_seen), 16'd0);

        // 2: bad parity on byte1 drops the packet; stray byte2 is not a header
        err_base = err_seen;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        chk("t2.par_err", 16'(err_seen - err_base), 16'd1);
        chk_out("t2.hold", 9'h005, 9'h1FB, 3'b001, 1'b1);
        send_byte(8'h10, 1'b0, 1'b0);
        chk("t2.sync_err", 16'(err_seen - err_base), 16'd2);
        send_pkt(8'h0A, 8'h03, 8'h04, 1'b0);
        chk_out("t2.next", 9'h003, 9'h004, 3'b010, 1'b0);

        // 3: header without sync bit rejected, then -128 / 0
        err_base = err_seen;
        send_byte(8'h00, 1'b0, 1'b0);
        chk("t3.err", 16'(err_seen - err_base), 16'd1);
        send_pkt(8'h18, 8'h80, 8'h00, 1'b0);
        chk_out("t3", 9'h180, 9'h000, 3'b000, 1'b1);

        // 4: X overflow saturates positive then negative
        send_pkt(8'h48, 8'h20, 8'h01, 1'b0);
        chk_out("t4.pos", 9'h0FF, 9'h001, 3'b000, 1'b0);
        send_pkt(8'h58, 8'h20, 8'h01, 1'b0);
        chk_out("t4.neg", 9'h100, 9'h001, 3'b000, 1'b1);

        // 5: stall after the header times out; next packet decodes normally
        err_base = err_seen;
        send_byte(8'h08, 1'b0, 1'b0);
        repeat (TIMEOUT_CYCLES + 10) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t5.timeout", 16'(err_seen - err_base), 16'd1);
        chk_out("t5.hold", 9'h100, 9'h001, 3'b000, 1'b1);
        send_pkt(8'h0C, 8'h07, 8'h09, 1'b0);
        chk_out("t5.next", 9'h007, 9'h009, 3'b100, 1'b0);
        chk("t5.no_extra_err", 16'(err_seen - err_base), 16'd1);

        // 6a: short clock glitches on every bit are filtered out
        err_base = err_seen;
        send_pkt(8'h09, 8'h11, 8'h22, 1'b1);
        chk_out("t6.glitch", 9'h011, 9'h022, 3'b001, 1'b1);
        chk("t6.glitch_err", 16'(err_seen - err_base), 16'd0);

        // 6b: reset mid-byte clears outputs immediately
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        @(negedge clk_sys);
        #1 reset_n = 1'b0;
        #1;
        chk_out("t6.reset", 9'h000, 9'h000, 3'b000, 1'b0);
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        repeat (5) @(posedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        send_pkt(8'h0B, 8'h01, 8'h02, 1'b0);
        chk_out("t6.after", 9'h001, 9'h002, 3'b011, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ps2_mouse_packet_rx
`default_nettype wire
